// File: rtl/rv_pkg.sv
// Shared RV32 decode constants used by the ID and EX stages.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_R) || (op == OP_IALU) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/rv_regfile.sv
// 31 x XLEN register file, two combinational read ports with write-through,
// one write port, asynchronous clear; x0 is hardwired to zero.
module rv_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] rf [32];
  logic            wr_en;

  assign wr_en = we && (waddr != 5'd0);
  assign rf[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      logic [XLEN-1:0] q_reg;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
          q_reg <= '0;
        else if (wr_en && (waddr == 5'(gi)))
          q_reg <= wdata;
      end
      assign rf[gi] = q_reg;
    end
  endgenerate

  // Bypass is gated by resetn so reads stay zero while the array is held clear.
  always_comb begin
    rdata1 = rf[raddr1];
    rdata2 = rf[raddr2];
    if (!resetn) begin
      rdata1 = '0;
      rdata2 = '0;
    end else begin
      if (wr_en && (waddr == raddr1)) rdata1 = wdata;
      if (wr_en && (waddr == raddr2)) rdata2 = wdata;
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32 instruction decode: field extract, immediate, control, load-use stall
// detection with a saturating stall counter, and the register file.
module id_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      instr,
  input  logic             instrValid,
  input  logic             wbRegWrite,
  input  logic [4:0]       wbRd,
  input  logic [XLEN-1:0]  wbData,
  input  logic             exMemRead,
  input  logic [4:0]       exRd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  rs1Data,
  output logic [XLEN-1:0]  rs2Data,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             memRead,
  output logic             memWrite,
  output logic             memToReg,
  output logic             regWrite,
  output logic             stall,
  output logic             illegal,
  output logic [CNT_W-1:0] stallCount
);

  logic [6:0]       opcode;
  logic             supported;
  logic             rs1_used;
  logic             rs2_used;
  logic             ctrl_en;
  logic [CNT_W-1:0] stall_count_reg;

  assign opcode    = instr[6:0];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign rd        = instr[11:7];
  assign supported = op_supported(opcode);
  assign rs1_used  = supported;
  assign rs2_used  = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  assign stall = instrValid && exMemRead && (exRd != 5'd0) &&
                 ((rs1_used && (exRd == rs1)) || (rs2_used && (exRd == rs2)));
  assign illegal = instrValid && !supported;
  assign ctrl_en = instrValid && !stall && supported;

  always_comb begin
    imm = '0;
    case (opcode)
      OP_IALU, OP_LOAD: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OP_STORE:         imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:        imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                               instr[30:25], instr[11:8], 1'b0};
      default:          imm = '0;
    endcase
  end

  // A bubble (stall, invalid or unsupported) drives every control to zero.
  always_comb begin
    ALUSrc   = 1'b0;
    ALUOp    = ALUOP_MEM;
    memRead  = 1'b0;
    memWrite = 1'b0;
    memToReg = 1'b0;
    regWrite = 1'b0;
    if (ctrl_en) begin
      case (opcode)
        OP_R: begin
          ALUOp    = ALUOP_R;
          regWrite = 1'b1;
        end
        OP_IALU: begin
          ALUSrc   = 1'b1;
          ALUOp    = ALUOP_I;
          regWrite = 1'b1;
        end
        OP_LOAD: begin
          ALUSrc   = 1'b1;
          memRead  = 1'b1;
          memToReg = 1'b1;
          regWrite = 1'b1;
        end
        OP_STORE: begin
          ALUSrc   = 1'b1;
          memWrite = 1'b1;
        end
        OP_BRANCH: ALUOp = ALUOP_BR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      stall_count_reg <= '0;
    else if (stall && (stall_count_reg != {CNT_W{1'b1}}))
      stall_count_reg <= stall_count_reg + 1'b1;
  end

  assign stallCount = stall_count_reg;

  // Writeback is never blocked by a stall; the stall only freezes upstream state.
  rv_regfile #(
    .XLEN(XLEN)
  ) u_regfile (
    .clk   (clk),
    .resetn(resetn),
    .we    (wbRegWrite),
    .waddr (wbRd),
    .wdata (wbData),
    .raddr1(rs1),
    .raddr2(rs2),
    .rdata1(rs1Data),
    .rdata2(rs2Data)
  );

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-computed vectors, one line per check.
module tb_id_stage;

  logic        clk;
  logic        resetn;
  logic [31:0] instr;
  logic        instrValid;
  logic        wbRegWrite;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
  logic        exMemRead;
  logic [4:0]  exRd;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, rs1Data, rs2Data;
  logic        ALUSrc;
  logic [1:0]  ALUOp;
  logic        memRead, memWrite, memToReg, regWrite;
  logic        stall, illegal;
  logic [15:0] stallCount;

  int n_tests = 0;
  int n_fail  = 0;
  int sc_exp  = 0;

  id_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .instr(instr), .instrValid(instrValid),
    .wbRegWrite(wbRegWrite), .wbRd(wbRd), .wbData(wbData),
    .exMemRead(exMemRead), .exRd(exRd),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .rs1Data(rs1Data), .rs2Data(rs2Data),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .regWrite(regWrite),
    .stall(stall), .illegal(illegal), .stallCount(stallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic [6:0] exp);
    check(tag, {25'd0, ALUSrc, ALUOp, memRead, memWrite, memToReg, regWrite}, {25'd0, exp});
  endtask

  initial begin
    resetn = 1'b0; instr = '0; instrValid = 1'b0;
    wbRegWrite = 1'b0; wbRd = '0; wbData = '0; exMemRead = 1'b0; exRd = '0;
    #2;
    check("rst_count", 32'(stallCount), 32'd0);
    check("rst_rs1data", rs1Data, 32'd0);

    // first write lands on the first rising edge after reset release
    @(negedge clk); resetn = 1'b1;
    wbRegWrite = 1'b1; wbRd = 5'd5; wbData = 32'hDEADBEEF;
    @(negedge clk); wbRegWrite = 1'b0; instr = 32'h000280B3; instrValid = 1'b1; #1;
    check("add_rs1data", rs1Data, 32'hDEADBEEF);
    check("add_rs2data", rs2Data, 32'd0);
    check("add_fields", {17'd0, rs1, rs2, rd}, {17'd0, 5'd5, 5'd0, 5'd1});
    // {ALUSrc,ALUOp[1:0],memRead,memWrite,memToReg,regWrite}
    check_ctrl("add_ctrl", 7'b0_10_0001);
    check("add_imm", imm, 32'd0);

    wbRegWrite = 1'b1; wbRd = 5'd5; wbData = 32'h12345678; #1;
    check("bypass_rs1", rs1Data, 32'h12345678);
    @(negedge clk); wbRegWrite = 1'b0; #1;
    check("stored_rs1", rs1Data, 32'h12345678);

    instr = 32'h006280B3; wbRegWrite = 1'b1; wbRd = 5'd6; wbData = 32'hCAFEF00D; #1;
    check("bypass_rs2", rs2Data, 32'hCAFEF00D);
    @(negedge clk); wbRegWrite = 1'b0;

    instr = 32'h00000033; wbRegWrite = 1'b1; wbRd = 5'd0; wbData = 32'h00001234; #1;
    check("x0_nobypass", rs1Data, 32'd0);
    @(negedge clk); wbRegWrite = 1'b0; #1;
    check("x0_read", rs1Data, 32'd0);

    // load-use stall on rs1 with a concurrent writeback to x7
    instr = 32'h006280B3; exMemRead = 1'b1; exRd = 5'd5;
    wbRegWrite = 1'b1; wbRd = 5'd7; wbData = 32'h00000077; #1;
    check("stall_rs1", 32'(stall), 32'd1);
    check_ctrl("stall_ctrl", 7'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); wbRegWrite = 1'b0; #1;
      sc_exp++;
      check($sformatf("stall_cnt%0d", i), 32'(stallCount), 32'(sc_exp));
    end
    exRd = 5'd6; #1;
    check("stall_rs2", 32'(stall), 32'd1);
    exRd = 5'd0; #1;
    check("no_stall_x0", 32'(stall), 32'd0);
    check_ctrl("no_stall_ctrl", 7'b0_10_0001);
    @(negedge clk); #1;
    check("cnt_hold", 32'(stallCount), 32'(sc_exp));
    exMemRead = 1'b0; instr = 32'h000380B3; #1;
    check("wb_during_stall", rs1Data, 32'h00000077);

    // addi x1,x5,6: rs2 field is immediate bits, so exRd==6 must not stall
    instr = 32'h00628093; exMemRead = 1'b1; exRd = 5'd6; #1;
    check("addi_nostall", 32'(stall), 32'd0);
    check_ctrl("addi_ctrl", 7'b1_11_0001);
    check("addi_imm", imm, 32'd6);
    exRd = 5'd5; #1;
    check("addi_stall_rs1", 32'(stall), 32'd1);
    exMemRead = 1'b0; exRd = 5'd0;

    instr = 32'h0082A103; #1;
    check_ctrl("lw_ctrl", 7'b1_00_1011);
    check("lw_imm", imm, 32'd8);
    instr = 32'hFE62AE23; #1;
    check_ctrl("sw_ctrl", 7'b1_00_0100);
    check("sw_imm", imm, 32'hFFFFFFFC);
    instr = 32'hFE628CE3; #1;
    check_ctrl("beq_ctrl", 7'b0_01_0000);
    check("beq_imm", imm, 32'hFFFFFFF8);

    instr = 32'h0000007F; #1;
    check("illegal_set", 32'(illegal), 32'd1);
    check_ctrl("illegal_ctrl", 7'b0);
    check("illegal_imm", imm, 32'd0);
    instrValid = 1'b0; #1;
    check("illegal_clr", 32'(illegal), 32'd0);
    instr = 32'h006280B3; exMemRead = 1'b1; exRd = 5'd5; #1;
    check("invalid_nostall", 32'(stall), 32'd0);
    check_ctrl("invalid_ctrl", 7'b0);

    // saturate the stall counter
    @(negedge clk); instrValid = 1'b1;
    repeat (65535 - sc_exp + 2) @(negedge clk);
    #1;
    check("cnt_saturate", 32'(stallCount), 32'h0000FFFF);

    // asynchronous reset mid-cycle clears regs and counter at once
    exMemRead = 1'b0; exRd = 5'd0; instr = 32'h000280B3; #1;
    check("pre_reset_x5", rs1Data, 32'h12345678);
    #1 resetn = 1'b0; #1;
    check("areset_cnt", 32'(stallCount), 32'd0);
    check("areset_x5", rs1Data, 32'd0);
    wbRegWrite = 1'b1; wbRd = 5'd5; wbData = 32'hAAAA5555; #1;
    check("reset_nobypass", rs1Data, 32'd0);
    check_ctrl("reset_ctrl", 7'b0_10_0001);
    @(negedge clk); wbRegWrite = 1'b0; resetn = 1'b1; #1;
    check("reset_write_ignored", rs1Data, 32'd0);
    wbRegWrite = 1'b1; wbRd = 5'd5; wbData = 32'h00000055;
    @(negedge clk); wbRegWrite = 1'b0; #1;
    check("post_reset_write", rs1Data, 32'h00000055);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
